// File: rtl/conv_window_sched_pkg.sv
// conv_window_sched_pkg: state encoding, default tree latency and output-map geometry
package conv_window_sched_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
    localparam int DEF_TREE_LAT = 3;
    function automatic int out_dim(input int n);
        return n - 2;
    endfunction
    function automatic int n_out(input int w, input int h);
        return out_dim(w) * out_dim(h);
    endfunction
endpackage

// File: rtl/conv_window_sched_raster_counter.sv
// raster_counter: row/col window position, wraps col at OUT_W-1, holds at the final position
module raster_counter #(
    parameter int OUT_W = 26,
    parameter int OUT_H = 26,
    parameter int RW = 5,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);
    logic col_end;
    always_comb begin
        col_end = col == CW'(OUT_W - 1);
        last = col_end && row == RW'(OUT_H - 1);
    end
    always_ff @(posedge clk) begin
        if (!rst || init) begin
            row <= '0;
            col <= '0;
        end else if (en && !last) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) row <= row + 1'b1;
        end
    end
endmodule

// File: rtl/conv_window_sched.sv
// conv_window_sched: raster-order 3x3 window sequencer with adder-tree enable and result tracking
module conv_window_sched
    import conv_window_sched_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int TREE_LAT = DEF_TREE_LAT
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   win_valid,
    input  logic                                   win_ready,
    output logic [$clog2(IMG_H)-1:0]               win_row,
    output logic [$clog2(IMG_W)-1:0]               win_col,
    output logic                                   tree,
    output logic                                   out_valid,
    output logic [$clog2(n_out(IMG_W, IMG_H))-1:0] out_addr
);
    localparam int SW = TREE_LAT - 1;
    localparam int DW = $clog2(TREE_LAT);
    state_t state, nxt;
    logic [SW-1:0] valid_sr;
    logic [DW-1:0] drain_cnt;
    logic issue, last, init;
    always_comb begin
        win_valid = state == RUN;
        issue = win_valid && win_ready;
        tree = issue || state == DRAIN;
        busy = state != IDLE;
        done = state == DONE;
        init = state == IDLE && start;
        nxt = state == IDLE  ? (start ? RUN : IDLE)
            : state == RUN   ? (issue && last ? DRAIN : RUN)
            : state == DRAIN ? (drain_cnt == DW'(TREE_LAT - 2) ? DONE : DRAIN)
            : IDLE;
    end
    // valid_sr shadows the tree stages: a bit enters only for a real issue
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            valid_sr <= '0;
            drain_cnt <= '0;
            out_valid <= 1'b0;
            out_addr <= '0;
        end else begin
            state <= nxt;
            out_valid <= tree && valid_sr[SW-1];
            if (init) begin
                valid_sr <= '0;
                drain_cnt <= '0;
                out_addr <= '0;
            end else begin
                if (tree) valid_sr <= SW'({valid_sr, issue});
                if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
                if (out_valid) out_addr <= out_addr + 1'b1;
            end
        end
    end
    raster_counter #(
        .OUT_W(out_dim(IMG_W)),
        .OUT_H(out_dim(IMG_H)),
        .RW($clog2(IMG_H)),
        .CW($clog2(IMG_W))
    ) u_pos (
        .clk(clk),
        .rst(rst),
        .init(init),
        .en(issue),
        .row(win_row),
        .col(win_col),
        .last(last)
    );
endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: randomized model check of the default map plus directed 4x4 timing cases
module tb_conv_window_sched;
    import conv_window_sched_pkg::*;
    localparam int W = 28, H = 28, L = DEF_TREE_LAT, OW = W - 2, N = (W - 2) * (H - 2);
    logic clk = 0, rst = 0, start = 0, win_ready = 0;
    logic busy, done, win_valid, tree, out_valid;
    logic [4:0] win_row, win_col;
    logic [9:0] out_addr;
    logic start4 = 0, ready4 = 0;
    logic busy4, done4, wv4, tree4, ov4;
    logic [1:0] row4, col4, addr4;
    int n_chk = 0, n_pass = 0;
    int a_tree[32], a_wv[32], a_row[32], a_col[32], a_ov[32], a_addr[32], a_done[32];

    always #5 clk = ~clk;

    conv_window_sched dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
        .tree(tree), .out_valid(out_valid), .out_addr(out_addr)
    );

    conv_window_sched #(.IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .win_valid(wv4), .win_ready(ready4), .win_row(row4), .win_col(col4),
        .tree(tree4), .out_valid(ov4), .out_addr(addr4)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " win_valid"}, win_valid, 0);
        chk({tag, " tree"}, tree, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " win_row"}, win_row, 0);
        chk({tag, " win_col"}, win_col, 0);
        chk({tag, " out_addr"}, out_addr, 0);
    endtask

    // Reference: issues follow win_ready, each result emerges after L tree-high cycles
    // counted from its issue cycle; addresses are handed out in result order.
    task automatic run_map(input string name, input int pct, input int mode,
                           output int done_cyc, output int n_ov);
        int issued = 0, tcnt = 0, drain = 0;
        int q[$];
        bit run = 0, pend_ov = 0, pend_done = 0, pend_fin = 0, fin = 0, hit_rst = 0;
        done_cyc = -1;
        n_ov = 0;
        for (int c = 0; c < 5000 && !fin && !hit_rst; c++) begin
            bit st, rdy, e_tree, e_busy, nd;
            @(posedge clk);
            #1;
            st = c == 0 || (mode == 1 && c == 100);
            rdy = $urandom_range(99) < pct;
            hit_rst = mode == 2 && run && issued == 10;
            rst = !hit_rst;
            start = st;
            win_ready = rdy;
            @(negedge clk);
            e_tree = run ? rdy : drain > 0;
            e_busy = run || drain > 0 || pend_done;
            chk($sformatf("%s c%0d win_valid", name, c), win_valid, run);
            chk($sformatf("%s c%0d tree", name, c), tree, e_tree);
            chk($sformatf("%s c%0d busy", name, c), busy, e_busy);
            chk($sformatf("%s c%0d done", name, c), done, pend_done);
            chk($sformatf("%s c%0d out_valid", name, c), out_valid, pend_ov);
            if (run) begin
                chk($sformatf("%s c%0d win_row", name, c), win_row, issued / OW);
                chk($sformatf("%s c%0d win_col", name, c), win_col, issued % OW);
            end
            if (pend_ov) begin
                chk($sformatf("%s c%0d out_addr", name, c), out_addr, n_ov);
                n_ov++;
            end
            if (pend_done) done_cyc = c;
            fin = pend_fin;
            pend_fin = pend_done;
            nd = drain == 1;
            pend_ov = 0;
            if (e_tree) begin
                tcnt++;
                if (run && rdy) q.push_back(tcnt);
                if (q.size() > 0 && q[0] == tcnt - L + 1) begin
                    pend_ov = 1;
                    void'(q.pop_front());
                end
            end
            if (drain > 0) drain--;
            if (run && rdy) begin
                issued++;
                if (issued == N) begin
                    run = 0;
                    drain = L - 1;
                end
            end
            if (!e_busy && st) run = 1;
            pend_done = nd;
        end
        if (!fin && !hit_rst) chk({name, " finished in budget"}, 0, 1);
    endtask

    task automatic run4(input int lo, input int hi);
        for (int c = 0; c < 32; c++) begin
            @(posedge clk);
            #1;
            start4 = c == 0;
            ready4 = !(c >= lo && c <= hi);
            @(negedge clk);
            a_tree[c] = tree4;
            a_wv[c] = wv4;
            a_row[c] = row4;
            a_col[c] = col4;
            a_ov[c] = ov4;
            a_addr[c] = addr4;
            a_done[c] = done4;
        end
    endtask

    initial begin
        int dc, nov, cnt_ov, cnt_done;
        repeat (3) @(posedge clk);
        #1;
        win_ready = 1;
        ready4 = 1;
        @(negedge clk);
        check_idle("reset");
        chk("reset dut4 busy", busy4, 0);
        chk("reset dut4 tree", tree4, 0);
        @(posedge clk);
        #1;
        rst = 1;

        run_map("full", 100, 0, dc, nov);
        chk("full out count", nov, N);
        chk("full done cycle", dc, N + L);

        run_map("restart", 100, 1, dc, nov);
        chk("restart out count", nov, N);
        chk("restart done cycle", dc, N + L);

        run_map("rstmid", 70, 2, dc, nov);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            rst = 1;
            start = 0;
            win_ready = 1;
            @(negedge clk);
            check_idle($sformatf("after rst c%0d", c));
        end
        run_map("fresh", 100, 0, dc, nov);
        chk("fresh out count", nov, N);
        chk("fresh done cycle", dc, N + L);

        run_map("rand60", 60, 0, dc, nov);
        chk("rand60 out count", nov, N);
        run_map("rand85", 85, 0, dc, nov);
        chk("rand85 out count", nov, N);

        run4(-1, -1);
        cnt_ov = 0;
        cnt_done = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("w4 issue%0d win_valid", k), a_wv[1 + k], 1);
            chk($sformatf("w4 issue%0d row", k), a_row[1 + k], k / 2);
            chk($sformatf("w4 issue%0d col", k), a_col[1 + k], k % 2);
            chk($sformatf("w4 result%0d out_valid", k), a_ov[4 + k], 1);
            chk($sformatf("w4 result%0d addr", k), a_addr[4 + k], k);
        end
        for (int c = 0; c < 32; c++) begin
            cnt_ov += a_ov[c];
            cnt_done += a_done[c];
        end
        chk("w4 out count", cnt_ov, 4);
        chk("w4 done count", cnt_done, 1);
        chk("w4 done at 7", a_done[7], 1);

        run4(2, 6);
        cnt_ov = 0;
        cnt_done = 0;
        for (int c = 2; c <= 6; c++) begin
            chk($sformatf("s4 c%0d tree", c), a_tree[c], 0);
            chk($sformatf("s4 c%0d row", c), a_row[c], 0);
            chk($sformatf("s4 c%0d col", c), a_col[c], 1);
        end
        chk("s4 c5 out_valid", a_ov[5], 0);
        chk("s4 c6 out_valid", a_ov[6], 0);
        for (int c = 0; c < 32; c++) begin
            cnt_ov += a_ov[c];
            cnt_done += a_done[c];
        end
        chk("s4 out count", cnt_ov, 4);
        chk("s4 done count", cnt_done, 1);
        chk("s4 done at 12", a_done[12], 1);
        chk("s4 last addr at 12", a_addr[12], 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
